tow_referee: RTL and testbench
==============================

// Module: tow_referee
// PURPOSE
//  Match sequencer for Tug of War. Turns two players' press levels into one-cycle
//  increment pulses for a pair of per-player score blocks. Freezes those blocks
//  (idle) between points and pulses their reset to serve a new point.
//  Counts points won per player and declares the match winner.
// PARAMETERS
//  SERVE_CYCLES   4  cycles in SERVE (field frozen) before play opens; >=1
//  HOLD_CYCLES    2  cycles in POINT (win frozen on LEDs) before next serve; >=1
//  POINTS_TO_WIN  3  points needed to win the match; 1..7
// PORTS
//  clk          in   1  system clock
//  reset        in   1  synchronous, active-high
//  press_l      in   1  left player button, debounced level
//  press_r      in   1  right player button, debounced level
//  win_l        in   1  win flag from left score block
//  win_r        in   1  win flag from right score block
//  inc_l        out  1  one-cycle increment pulse to left score block
//  inc_r        out  1  one-cycle increment pulse to right score block
//  idle         out  2  freeze to both score blocks; 2'b11 frozen, 2'b00 live
//  score_rst    out  1  one-cycle reset to both score blocks
//  points_l     out  3  points won by left
//  points_r     out  3  points won by right
//  match_over   out  1  high once a player reaches POINTS_TO_WIN
//  winner_r     out  1  valid when match_over: 1 = right won, 0 = left won
// BEHAVIOUR
//  - Single clock. Synchronous active-high reset. All outputs are registered.
//  - Reset values:
//    - state=SERVE, timer=0, score_rst=1, idle=2'b11, inc_l/inc_r=0.
//    - points=0, match_over=0, winner_r=0, edge-detect history regs=1 (no false edge).
//  - Edge detect:
//    - rise_x = press_x & ~press_q_x. press_q_x updates every cycle in every state.
//    - A press held across a state change never produces an edge.
//  - SERVE:
//    - idle=11. score_rst=1 on the first SERVE cycle only. timer counts up.
//    - After SERVE_CYCLES cycles in SERVE -> PLAY, timer cleared. Rises are ignored.
//  - PLAY:
//    - idle=00.
//    - rise_l & ~rise_r -> inc_l=1 the next cycle. Mirror for the right player.
//    - rise_l & rise_r in the same cycle -> cancel, no pulse.
//    - Latency: press sampled high at edge k -> inc high for cycle k..k+1, exactly one cycle.
//    - win_l & ~win_r -> points_l+1, go to POINT. Mirror for the right player.
//    - win_l & win_r -> no point awarded, go to SERVE (replay).
//    - Rises in the cycle a win is seen are dropped.
//  - POINT:
//    - idle=11, inc=0. Hold HOLD_CYCLES cycles.
//    - Then, if points_x == POINTS_TO_WIN -> MATCH, else -> SERVE.
//  - MATCH:
//    - idle=11. match_over=1, winner_r set. Points frozen.
//    - Stays until reset; presses and wins are ignored.
//  - Points saturate at POINTS_TO_WIN and never wrap.
//  - Reset mid-PLAY or mid-POINT: return to reset values on the next edge.
//    A pending inc pulse is dropped.
// TESTING (SERVE_CYCLES=4, HOLD_CYCLES=2, POINTS_TO_WIN=2)
//  1. Reset 1 cycle, release -> score_rst=1 for 1 cycle, idle=11 for 4 cycles, then idle=00.
//  2. PLAY, press_l 0->1 held 5 cycles -> inc_l=1 exactly one cycle, one cycle after the rise; inc_r=0.
//  3. PLAY, press_l and press_r rise together -> no inc pulse.
//     Next, press_r alone rises -> inc_r one cycle.
//  4. Press held through SERVE into PLAY -> no inc. Release, then press again -> one inc pulse.
//  5. win_r=1 in PLAY -> points_r=1, idle=11 for 2 cycles, score_rst pulse, serve again.
//     A second win_r -> points_r=2, match_over=1, winner_r=1, stays put.
//  6. win_l=win_r=1 -> points unchanged, back to SERVE.
//     Separately, reset asserted mid-POINT -> all outputs return to reset values.

Source files
------------

// File: rtl/tow_referee.sv
// rtl/tow_referee.sv - Tug of War match sequencer: serve, play, point hold, match end
module tow_referee #(
    parameter int SERVE_CYCLES  = 4,
    parameter int HOLD_CYCLES   = 2,
    parameter int POINTS_TO_WIN = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       press_l,
    input  logic       press_r,
    input  logic       win_l,
    input  logic       win_r,
    output logic       inc_l,
    output logic       inc_r,
    output logic [1:0] idle,
    output logic       score_rst,
    output logic [2:0] points_l,
    output logic [2:0] points_r,
    output logic       match_over,
    output logic       winner_r
);

    localparam int TMAX = (SERVE_CYCLES > HOLD_CYCLES) ? SERVE_CYCLES : HOLD_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] SERVE_LAST = TW'(SERVE_CYCLES - 1);
    localparam logic [TW-1:0] HOLD_LAST  = TW'(HOLD_CYCLES - 1);
    localparam logic [2:0]    WIN_PTS    = 3'(POINTS_TO_WIN);

    typedef enum logic [1:0] {
        SERVE = 2'd0,
        PLAY  = 2'd1,
        POINT = 2'd2,
        MATCH = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          press_q_l, press_q_r;
    logic          rise_l, rise_r;

    logic          inc_l_d, inc_r_d;
    logic [1:0]    idle_d;
    logic          score_rst_d;
    logic [2:0]    points_l_d, points_r_d;
    logic          match_over_d, winner_r_d;

    // History regs start high so a button already held at reset is not an edge.
    assign rise_l = press_l & ~press_q_l;
    assign rise_r = press_r & ~press_q_r;

    // State, timer, edge history and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= SERVE;
            timer_q    <= '0;
            press_q_l  <= 1'b1;
            press_q_r  <= 1'b1;
            inc_l      <= 1'b0;
            inc_r      <= 1'b0;
            idle       <= 2'b11;
            score_rst  <= 1'b1;
            points_l   <= 3'd0;
            points_r   <= 3'd0;
            match_over <= 1'b0;
            winner_r   <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            press_q_l  <= press_l;
            press_q_r  <= press_r;
            inc_l      <= inc_l_d;
            inc_r      <= inc_r_d;
            idle       <= idle_d;
            score_rst  <= score_rst_d;
            points_l   <= points_l_d;
            points_r   <= points_r_d;
            match_over <= match_over_d;
            winner_r   <= winner_r_d;
        end
    end

    // Next state plus the output values that belong to the state being entered.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        inc_l_d      = 1'b0;
        inc_r_d      = 1'b0;
        idle_d       = 2'b11;
        score_rst_d  = 1'b0;
        points_l_d   = points_l;
        points_r_d   = points_r;
        match_over_d = match_over;
        winner_r_d   = winner_r;

        case (state_q)
            SERVE: begin
                if (timer_q == SERVE_LAST) begin
                    state_d = PLAY;
                    timer_d = '0;
                    idle_d  = 2'b00;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            PLAY: begin
                if (win_l || win_r) begin
                    timer_d = '0;
                    if (win_l && !win_r) begin
                        points_l_d = (points_l == WIN_PTS) ? points_l : points_l + 3'd1;
                        state_d    = POINT;
                    end else if (win_r && !win_l) begin
                        points_r_d = (points_r == WIN_PTS) ? points_r : points_r + 3'd1;
                        state_d    = POINT;
                    end else begin
                        // Simultaneous wins are a replay: nobody scores.
                        state_d     = SERVE;
                        score_rst_d = 1'b1;
                    end
                end else begin
                    idle_d  = 2'b00;
                    inc_l_d = rise_l & ~rise_r;
                    inc_r_d = rise_r & ~rise_l;
                end
            end

            POINT: begin
                if (timer_q == HOLD_LAST) begin
                    timer_d = '0;
                    if (points_l == WIN_PTS || points_r == WIN_PTS) begin
                        state_d      = MATCH;
                        match_over_d = 1'b1;
                        winner_r_d   = (points_r == WIN_PTS);
                    end else begin
                        state_d     = SERVE;
                        score_rst_d = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            default: begin
                state_d = MATCH;
            end
        endcase
    end

endmodule

// File: tb/tb_tow_referee.sv
// tb/tb_tow_referee.sv - directed self-checking bench for tow_referee
module tb_tow_referee;

    logic       clk;
    logic       reset;
    logic       press_l, press_r, win_l, win_r;
    logic       inc_l, inc_r;
    logic [1:0] idle;
    logic       score_rst;
    logic [2:0] points_l, points_r;
    logic       match_over, winner_r;

    int checks = 0;
    int errors = 0;

    tow_referee #(
        .SERVE_CYCLES (4),
        .HOLD_CYCLES  (2),
        .POINTS_TO_WIN(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .press_l   (press_l),
        .press_r   (press_r),
        .win_l     (win_l),
        .win_r     (win_r),
        .inc_l     (inc_l),
        .inc_r     (inc_r),
        .idle      (idle),
        .score_rst (score_rst),
        .points_l  (points_l),
        .points_r  (points_r),
        .match_over(match_over),
        .winner_r  (winner_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_score_rst"}, 32'(score_rst), 1);
        check({tag, "_idle"}, 32'(idle), 3);
        check({tag, "_inc_l"}, 32'(inc_l), 0);
        check({tag, "_inc_r"}, 32'(inc_r), 0);
        check({tag, "_points_l"}, 32'(points_l), 0);
        check({tag, "_points_r"}, 32'(points_r), 0);
        check({tag, "_match_over"}, 32'(match_over), 0);
        check({tag, "_winner_r"}, 32'(winner_r), 0);
    endtask

    initial begin
        reset = 1'b1; press_l = 1'b0; press_r = 1'b0; win_l = 1'b0; win_r = 1'b0;
        cyc(2);

        // 1: reset values, then one score_rst cycle and four frozen cycles
        check_reset_values("rst1");
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("serve_idle_%0d", i), 32'(idle), 3);
            check($sformatf("serve_srst_%0d", i), 32'(score_rst), (i == 0) ? 1 : 0);
            cyc(1);
        end
        check("play_idle", 32'(idle), 0);

        // 2: single rise on the left gives exactly one pulse, one cycle later
        press_l = 1'b1;
        cyc(1);
        check("l_pulse", 32'(inc_l), 1);
        check("l_pulse_r", 32'(inc_r), 0);
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            check($sformatf("l_held_%0d", i), 32'(inc_l), 0);
        end
        press_l = 1'b0;
        cyc(1);

        // 3: simultaneous rises cancel, then a lone right rise pulses
        press_l = 1'b1; press_r = 1'b1;
        cyc(1);
        check("both_inc_l", 32'(inc_l), 0);
        check("both_inc_r", 32'(inc_r), 0);
        press_l = 1'b0; press_r = 1'b0;
        cyc(1);
        press_r = 1'b1;
        cyc(1);
        check("r_pulse", 32'(inc_r), 1);
        check("r_pulse_l", 32'(inc_l), 0);
        press_r = 1'b0;
        cyc(1);
        check("r_pulse_end", 32'(inc_r), 0);

        // 5a: right wins a point, hold two cycles, then a new serve
        win_r = 1'b1;
        cyc(1);
        win_r = 1'b0;
        check("pt1_points_r", 32'(points_r), 1);
        check("pt1_points_l", 32'(points_l), 0);
        check("pt1_idle", 32'(idle), 3);
        check("pt1_srst", 32'(score_rst), 0);
        cyc(1);
        check("pt1_hold_idle", 32'(idle), 3);
        check("pt1_hold_srst", 32'(score_rst), 0);
        cyc(1);
        check("reserve_srst", 32'(score_rst), 1);
        check("reserve_idle", 32'(idle), 3);

        // 4: press held through the serve into play never pulses
        press_l = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            check($sformatf("held_serve_inc_%0d", i), 32'(inc_l), 0);
        end
        check("held_play_idle", 32'(idle), 0);
        cyc(1);
        check("held_play_inc", 32'(inc_l), 0);
        press_l = 1'b0;
        cyc(1);
        press_l = 1'b1;
        cyc(1);
        check("repress_inc", 32'(inc_l), 1);
        press_l = 1'b0;
        cyc(1);
        check("repress_end", 32'(inc_l), 0);

        // 5b: second right point ends the match
        win_r = 1'b1;
        cyc(1);
        win_r = 1'b0;
        check("pt2_points_r", 32'(points_r), 2);
        check("pt2_match_early", 32'(match_over), 0);
        cyc(2);
        check("match_over", 32'(match_over), 1);
        check("match_winner", 32'(winner_r), 1);
        check("match_idle", 32'(idle), 3);
        check("match_srst", 32'(score_rst), 0);
        press_l = 1'b1; win_l = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            check($sformatf("frozen_pl_%0d", i), 32'(points_l), 0);
            check($sformatf("frozen_pr_%0d", i), 32'(points_r), 2);
            check($sformatf("frozen_mo_%0d", i), 32'(match_over), 1);
            check($sformatf("frozen_inc_%0d", i), 32'(inc_l), 0);
        end
        press_l = 1'b0; win_l = 1'b0;

        // 6a: reset clears the match; simultaneous wins replay the serve
        reset = 1'b1;
        cyc(1);
        check_reset_values("rst2");
        reset = 1'b0;
        cyc(4);
        check("replay_play_idle", 32'(idle), 0);
        win_l = 1'b1; win_r = 1'b1;
        cyc(1);
        win_l = 1'b0; win_r = 1'b0;
        check("replay_points_l", 32'(points_l), 0);
        check("replay_points_r", 32'(points_r), 0);
        check("replay_srst", 32'(score_rst), 1);
        check("replay_idle", 32'(idle), 3);

        // 6b: reset asserted in the middle of a point
        cyc(4);
        check("p6_play_idle", 32'(idle), 0);
        win_l = 1'b1;
        cyc(1);
        win_l = 1'b0;
        check("p6_points_l", 32'(points_l), 1);
        reset = 1'b1;
        cyc(1);
        check_reset_values("rst3");
        reset = 1'b0;
        cyc(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
